// File: rtl/dst_mac_filter_pkg.sv
// Shared definitions for the destination-MAC filter: FSM encodings,
// broadcast address, multicast bit position and DA field bounds.
package dst_mac_filter_pkg;

    localparam int unsigned MAC_W     = 48;
    localparam int unsigned DA_HI     = 63;
    localparam int unsigned DA_LO     = 16;
    localparam int unsigned MCAST_BIT = 40;

    localparam logic [MAC_W-1:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef enum logic {
        PRE_DA  = 1'b0,
        POST_DA = 1'b1
    } parser_state_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } out_state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head entry whenever
// empty is low; synchronous active-high reset flushes it.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr       = wr_en & ~full;
    assign do_rd       = rd_en & ~empty;
    assign dout        = mem[rd_ptr];
    assign full        = (count == CNT_W'(DEPTH));
    assign nearly_full = (count == CNT_W'(DEPTH - 1));
    assign empty       = (count == '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dst_mac_filter.sv
// Destination-MAC packet filter: buffers packets, decides accept/drop on the
// DA word, then forwards or discards. Optional stats via DST_MAC_FILTER_STATS_EN.
module dst_mac_filter
    import dst_mac_filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned FIFO_DEPTH_BITS = 3,
    parameter int unsigned DEC_DEPTH_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [MAC_W-1:0]      mac_addr,
    input  logic                  filter_en,
    input  logic                  accept_mcast,
    input  logic                  promisc,
    output logic                  pkt_passed,
    output logic                  pkt_dropped
`ifdef DST_MAC_FILTER_STATS_EN
    ,
    output logic [31:0]           num_passed,
    output logic [31:0]           num_dropped
`endif
);

    localparam int unsigned FIFO_W = DATA_WIDTH + CTRL_WIDTH;

    parser_state_t         in_state;
    out_state_t            state;
    out_state_t            state_nxt;
    logic                  wr_accept;
    logic                  da_word;
    logic [MAC_W-1:0]      da;
    logic                  accept;
    logic [FIFO_W-1:0]     data_head;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  d_full, d_nfull, d_empty;
    logic                  q_full, q_nfull, q_empty;
    logic                  dec_head;
    logic                  data_rd;
    logic                  dec_rd;
    logic                  fwd_mode;
    logic                  rd_seen_da;
    logic                  rd_eop;
    logic                  d_full_nxt;
    logic                  q_full_nxt;

    // Input side: accept words, classify DA, compute the decision bit
    assign wr_accept = in_wr & in_rdy;
    assign da_word   = (in_state == PRE_DA) && (in_ctrl == '0);
    assign da        = in_data[DA_HI:DA_LO];
    assign accept    = ~filter_en | promisc | (da == mac_addr)
                     | (da == BROADCAST_ADDR) | (accept_mcast & da[MCAST_BIT]);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state <= PRE_DA;
        end else if (wr_accept) begin
            if (da_word) begin
                in_state <= POST_DA;
            end else if (in_state == POST_DA && in_ctrl != '0) begin
                in_state <= PRE_DA;
            end
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_data_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (wr_accept),
        .rd_en       (data_rd),
        .dout        (data_head),
        .full        (d_full),
        .nearly_full (d_nfull),
        .empty       (d_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (1),
        .MAX_DEPTH_BITS (DEC_DEPTH_BITS)
    ) u_dec_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (accept),
        .wr_en       (wr_accept & da_word),
        .rd_en       (dec_rd),
        .dout        (dec_head),
        .full        (q_full),
        .nearly_full (q_nfull),
        .empty       (q_empty)
    );

    // Look one cycle ahead so in_rdy is already low when a FIFO becomes full
    assign d_full_nxt = (d_full & ~data_rd) | (d_nfull & wr_accept & ~data_rd);
    assign q_full_nxt = (q_full & ~dec_rd) | (q_nfull & wr_accept & da_word & ~dec_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_rdy <= 1'b0;
        end else begin
            in_rdy <= ~d_full_nxt & ~q_full_nxt;
        end
    end

    // Output side: read-side DA tracking locates the EOP word
    assign head_ctrl = data_head[FIFO_W-1:DATA_WIDTH];
    assign head_data = data_head[DATA_WIDTH-1:0];
    assign rd_eop    = rd_seen_da && (head_ctrl != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_seen_da <= 1'b0;
        end else if (data_rd) begin
            if (rd_eop) begin
                rd_seen_da <= 1'b0;
            end else if (head_ctrl == '0) begin
                rd_seen_da <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_nxt = dec_head ? ST_FORWARD : ST_DROP;
                end
            end
            ST_FORWARD, ST_DROP: begin
                if (data_rd && rd_eop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The entry cycle already reads, which keeps minimum latency at two cycles
    always_comb begin
        data_rd  = 1'b0;
        dec_rd   = 1'b0;
        fwd_mode = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    dec_rd   = 1'b1;
                    fwd_mode = dec_head;
                    data_rd  = ~d_empty & (out_rdy | ~dec_head);
                end
            end
            ST_FORWARD: begin
                fwd_mode = 1'b1;
                data_rd  = ~d_empty & out_rdy;
            end
            ST_DROP: begin
                data_rd = ~d_empty;
            end
            default: begin
                data_rd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr      <= 1'b0;
            out_data    <= '0;
            out_ctrl    <= '0;
            pkt_passed  <= 1'b0;
            pkt_dropped <= 1'b0;
        end else begin
            out_wr      <= data_rd & fwd_mode;
            pkt_passed  <= data_rd & rd_eop & fwd_mode;
            pkt_dropped <= data_rd & rd_eop & ~fwd_mode;
            if (data_rd && fwd_mode) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

`ifdef DST_MAC_FILTER_STATS_EN
    // Saturating packet counters
    always_ff @(posedge clk) begin
        if (reset) begin
            num_passed  <= '0;
            num_dropped <= '0;
        end else begin
            if (pkt_passed && num_passed != '1) begin
                num_passed <= num_passed + 32'd1;
            end
            if (pkt_dropped && num_dropped != '1) begin
                num_dropped <= num_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dst_mac_filter.sv
// Directed self-checking bench for dst_mac_filter.
module tb_dst_mac_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [47:0] mac_addr;
    logic        filter_en;
    logic        accept_mcast;
    logic        promisc;
    logic        pkt_passed;
    logic        pkt_dropped;
`ifdef DST_MAC_FILTER_STATS_EN
    logic [31:0] num_passed;
    logic [31:0] num_dropped;
`endif

    always #5 clk = ~clk;

    dst_mac_filter dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_rdy       (in_rdy),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy),
        .mac_addr     (mac_addr),
        .filter_en    (filter_en),
        .accept_mcast (accept_mcast),
        .promisc      (promisc),
        .pkt_passed   (pkt_passed),
        .pkt_dropped  (pkt_dropped)
`ifdef DST_MAC_FILTER_STATS_EN
        ,
        .num_passed   (num_passed),
        .num_dropped  (num_dropped)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [71:0] got_q[$];
    int          got_cyc_q[$];
    int          pass_cnt = 0;
    int          drop_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_wr) begin
                got_q.push_back({out_ctrl, out_data});
                got_cyc_q.push_back(cyc);
            end
            if (pkt_passed)  pass_cnt++;
            if (pkt_dropped) drop_cnt++;
        end
    end

    logic [71:0] exp_q[$];
    int          chk_idx = 0;
    int          errors = 0;
    int          checks = 0;
    int          da_cyc = 0;
    int          tot = 0;
    int          base = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input logic [7:0] c, input logic [63:0] d, output int acc);
        int n;
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        n = 0;
        while (!in_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("in_rdy_timeout", 72'(n), 72'(0));
        acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input logic [47:0] da, input logic [7:0] tag, input int nhdr,
                            input bit pass, input int flip_at);
        for (int i = 0; i < nhdr + 8; i++) begin
            logic [7:0]  c;
            logic [63:0] d;
            int          a;
            if (i < nhdr) begin
                c = 8'hFF; d = {tag, 8'(i), 48'hC0DE_0000_0000};
            end else if (i == nhdr) begin
                c = 8'h00; d = {da, tag, 8'h55};
            end else if (i == nhdr + 7) begin
                c = 8'h40; d = {tag, 8'(i), 48'hE0F0_0000_0001};
            end else begin
                c = 8'h00; d = {tag, 8'(i), 48'h1234_5678_9ABC};
            end
            if (i == flip_at) promisc = 1'b1;
            if (pass) exp_q.push_back({c, d});
            put_word(c, d, a);
            if (i == nhdr) da_cyc = a;
        end
        in_wr = 1'b0;
    endtask

    task automatic wait_pkts(input int target);
        int n;
        n = 0;
        while ((pass_cnt + drop_cnt) < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 72'(n < 300), 72'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_words();
        while (chk_idx < got_q.size() && chk_idx < exp_q.size()) begin
            check($sformatf("word%0d", chk_idx), got_q[chk_idx], exp_q[chk_idx]);
            chk_idx++;
        end
        check("word_count", 72'(got_q.size()), 72'(exp_q.size()));
    endtask

    initial begin
        in_wr        = 1'b0;
        in_data      = '0;
        in_ctrl      = '0;
        out_rdy      = 1'b1;
        mac_addr     = 48'h004E_4632_4300;
        filter_en    = 1'b1;
        accept_mcast = 1'b0;
        promisc      = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy",   72'(in_rdy),   72'(0));
        check("rst_out_wr",   72'(out_wr),   72'(0));
        check("rst_out_data", 72'(out_data), 72'(0));
        check("rst_out_ctrl", 72'(out_ctrl), 72'(0));
        check("rst_pulses",   72'({pkt_passed, pkt_dropped}), 72'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("in_rdy_after_rst", 72'(in_rdy), 72'(1));

        // Unicast to own address passes; DA word emerges two cycles after write
        send_pkt(48'h004E_4632_4300, 8'h01, 0, 1'b1, -1);
        wait_pkts(++tot);
        check("t1_pass", 72'(pass_cnt), 72'(1));
        check("t1_drop", 72'(drop_cnt), 72'(0));
        check("t1_latency", 72'(got_cyc_q[0] - da_cyc), 72'(2));
        compare_words();

        // Mismatch dropped, then matching packet back-to-back with no output gap
        base = got_q.size();
        send_pkt(48'h0011_2233_4455, 8'h02, 0, 1'b0, -1);
        send_pkt(48'h004E_4632_4300, 8'h03, 0, 1'b1, -1);
        tot += 2;
        wait_pkts(tot);
        check("t2_drop", 72'(drop_cnt), 72'(1));
        check("t2_pass", 72'(pass_cnt), 72'(2));
        check("t2_no_gap", 72'(got_cyc_q[base + 7] - got_cyc_q[base]), 72'(7));
        compare_words();

        // One-bit DA difference drops; promisc raised mid-packet does not rescue it
        send_pkt(48'h004E_4632_4301, 8'h04, 0, 1'b0, 3);
        promisc = 1'b0;
        wait_pkts(++tot);
        check("t3_midpkt_ctrl", 72'(drop_cnt), 72'(2));

        // Multicast with and without accept_mcast, broadcast, promisc, filter off
        send_pkt(48'h0100_5E00_0001, 8'h05, 0, 1'b0, -1);
        wait_pkts(++tot);
        check("t4_mcast_off", 72'(drop_cnt), 72'(3));
        accept_mcast = 1'b1;
        send_pkt(48'h0100_5E00_0001, 8'h06, 0, 1'b1, -1);
        wait_pkts(++tot);
        check("t4_mcast_on", 72'(pass_cnt), 72'(3));
        accept_mcast = 1'b0;
        send_pkt(48'hFFFF_FFFF_FFFF, 8'h07, 0, 1'b1, -1);
        wait_pkts(++tot);
        check("t4_bcast", 72'(pass_cnt), 72'(4));
        promisc = 1'b1;
        send_pkt(48'h0011_2233_4466, 8'h08, 0, 1'b1, -1);
        wait_pkts(++tot);
        check("t4_promisc", 72'(pass_cnt), 72'(5));
        promisc   = 1'b0;
        filter_en = 1'b0;
        send_pkt(48'h0A0B_0C0D_0E0F, 8'h09, 0, 1'b1, -1);
        wait_pkts(++tot);
        check("t4_filter_off", 72'(pass_cnt), 72'(6));
        filter_en = 1'b1;
        check("t4_drop_total", 72'(drop_cnt), 72'(3));
        compare_words();

        // Downstream stall: FIFO fills, in_rdy falls, nothing lost or duplicated
        out_rdy = 1'b0;
        base = got_q.size();
        fork
            begin
                send_pkt(48'h004E_4632_4300, 8'h20, 0, 1'b1, -1);
                send_pkt(48'h004E_4632_4300, 8'h21, 0, 1'b1, -1);
                send_pkt(48'h004E_4632_4300, 8'h22, 0, 1'b1, -1);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                check("t5_in_rdy_full", 72'(in_rdy), 72'(0));
                check("t5_no_out_stall", 72'(got_q.size()), 72'(base));
                out_rdy = 1'b1;
            end
        join
        tot += 3;
        wait_pkts(tot);
        check("t5_pass", 72'(pass_cnt), 72'(9));
        compare_words();

        // Reset in the middle of a packet (one header + DA)
        begin
            int a;
            put_word(8'hFF, {8'h30, 8'h00, 48'hC0DE_0000_0000}, a);
            put_word(8'h00, {48'h0011_2233_4455, 8'h30, 8'h55}, a);
            in_wr = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_in_rdy",   72'(in_rdy),   72'(0));
        check("mrst_out_wr",   72'(out_wr),   72'(0));
        check("mrst_out_data", 72'(out_data), 72'(0));
        check("mrst_out_ctrl", 72'(out_ctrl), 72'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mrst_in_rdy_after", 72'(in_rdy), 72'(1));
        send_pkt(48'h004E_4632_4300, 8'h31, 1, 1'b1, -1);
        wait_pkts(++tot);
        check("t6_pass", 72'(pass_cnt), 72'(10));
        check("t6_drop", 72'(drop_cnt), 72'(3));
        compare_words();

`ifdef DST_MAC_FILTER_STATS_EN
        check("stat_passed",  72'(num_passed),  72'(1));
        check("stat_dropped", 72'(num_dropped), 72'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
